// File: rtl/pe_inject_ctrl_pkg.sv
// noc_pkg: packet field positions and route encodings shared with the router arbitrators
package noc_pkg;
  localparam int VC_BIT = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_HI = 55;
  localparam int HOP_LO = 48;
  localparam int PAY_HI = 47;
  localparam int ENTRY_W = 57;
  localparam logic DIR_CW = 1'b0;
  localparam logic DIR_CCW = 1'b1;
  typedef struct packed {
    logic dir;
    logic [7:0] hop;
    logic [47:0] payload;
  } entry_t;
endpackage

// File: rtl/pe_inject_ctrl_if.sv
// pe_inject_ctrl_if: core request and PE buffer signals of one injection port
interface pe_inject_ctrl_if #(parameter int DEPTH = 4);
  logic core_req;
  logic [7:0] core_dest;
  logic [47:0] core_payload;
  logic core_gnt;
  logic core_err;
  logic polarity;
  logic pe_full_even;
  logic pe_full_odd;
  logic [63:0] pe_data;
  logic pe_write;
  logic [$clog2(DEPTH):0] fifo_count;
  logic stall;
  modport slave (
    input core_req, core_dest, core_payload, polarity, pe_full_even, pe_full_odd,
    output core_gnt, core_err, pe_data, pe_write, fifo_count, stall
  );
  modport master (
    output core_req, core_dest, core_payload, polarity, pe_full_even, pe_full_odd,
    input core_gnt, core_err, pe_data, pe_write, fifo_count, stall
  );
endinterface

// File: rtl/pe_inject_ctrl_fifo.sv
// inject_fifo: synchronous FIFO with occupancy count and async active-high reset
module inject_fifo #(
  parameter int WIDTH = 57,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push && (cnt_q < (AW+1)'(DEPTH));
  assign do_pop = pop && (cnt_q != '0);
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/pe_inject_ctrl.sv
// pe_inject_ctrl: queues core packets, routes them around the ring and injects into the idle VC
module pe_inject_ctrl
  import noc_pkg::*;
#(
  parameter int NODES = 4,
  parameter int NODE_ID = 0,
  parameter int DEPTH = 4,
  parameter int STALL_LIM = 16
) (
  input logic clk,
  input logic reset,
  pe_inject_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [7:0] N8 = 8'(NODES);
  localparam logic [7:0] ID8 = 8'(NODE_ID);
  localparam logic [7:0] HALF = 8'(NODES / 2);
  entry_t in_e, head_e;
  logic [7:0] d_ring, stall_q, stall_d;
  logic [CW-1:0] cnt;
  logic dest_ok, vc, full_sel, nonempty, push, pop;
  logic [63:0] pkt;
  assign dest_ok = (bus.core_dest < N8) && (bus.core_dest != ID8);
  // dest < NODES whenever the result is used, so the wrap add never overflows
  assign d_ring = bus.core_dest >= ID8 ? bus.core_dest - ID8 : bus.core_dest + (N8 - ID8);
  assign in_e.dir = d_ring > HALF ? DIR_CCW : DIR_CW;
  assign in_e.hop = d_ring > HALF ? N8 - d_ring : d_ring;
  assign in_e.payload = bus.core_payload;
  assign push = bus.core_req && dest_ok && (cnt < CW'(DEPTH));
  assign nonempty = cnt != '0;
  assign vc = ~bus.polarity;
  assign full_sel = vc ? bus.pe_full_odd : bus.pe_full_even;
  assign pop = nonempty && !full_sel;
  inject_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(in_e),
    .dout(head_e),
    .count(cnt)
  );
  always_comb begin
    pkt = '0;
    pkt[VC_BIT] = vc;
    pkt[DIR_BIT] = head_e.dir;
    pkt[HOP_HI:HOP_LO] = head_e.hop;
    pkt[PAY_HI:0] = head_e.payload;
    pkt = nonempty ? pkt : '0;
  end
  assign stall_d = (!nonempty || pop) ? 8'd0 : (stall_q == 8'hff ? stall_q : stall_q + 8'd1);
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  assign bus.core_gnt = push;
  assign bus.core_err = bus.core_req && !dest_ok;
  assign bus.pe_write = pop;
  assign bus.pe_data = pkt;
  assign bus.fifo_count = cnt;
  assign bus.stall = stall_q >= 8'(STALL_LIM);
endmodule
